ase_svfifo: RTL and testbench

ASE_SVFIFO -- requirements
Module: ase_svfifo

---
 rtl/ase_svfifo_pkg.sv | 14 +
 rtl/ase_svfifo_ram.sv | 44 ++++
 rtl/ase_svfifo.sv | 121 ++++++++++++
 tb/tb_ase_svfifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ase_svfifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ase_svfifo_pkg                                                  |
// | Brief    : Shared default configuration values for the ase_svfifo family.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package ase_svfifo_pkg;

    localparam int c_DEF_DATA_WIDTH     = 64;
    localparam int c_DEF_DEPTH_BASE2    = 4;
    localparam int c_DEF_ALMFULL_THRESH = 5;

endpackage : ase_svfifo_pkg
`default_nettype wire

// File: rtl/ase_svfifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ase_svfifo_ram                                                  |
// | Brief    : Simple dual-port storage, one write port, one registered read.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ase_svfifo_ram
    import ase_svfifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_DEPTH_BASE2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Only the read register is reset; the array itself is never cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : ase_svfifo_ram
`default_nettype wire

// File: rtl/ase_svfifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ase_svfifo                                                      |
// | Brief    : Synchronous FIFO with count, almost-full and error pulses.      |
// |            Define ASE_SVFIFO_ERRCHK_EN to enable overflow/underflow.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ase_svfifo
    import ase_svfifo_pkg::*;
#(
    parameter int DATA_WIDTH     = c_DEF_DATA_WIDTH,
    parameter int DEPTH_BASE2    = c_DEF_DEPTH_BASE2,
    parameter int ALMFULL_THRESH = c_DEF_ALMFULL_THRESH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_out_v,
    output logic                   alm_full,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_BASE2:0]   count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int                     c_DEPTH    = 2**DEPTH_BASE2;
    localparam logic [DEPTH_BASE2:0]   c_CNT_FULL = (DEPTH_BASE2+1)'(c_DEPTH);
    localparam logic [DEPTH_BASE2:0]   c_CNT_ALM  = (DEPTH_BASE2+1)'(c_DEPTH - ALMFULL_THRESH);
    localparam logic [DEPTH_BASE2:0]   c_CNT_ONE  = (DEPTH_BASE2+1)'(1);
    localparam logic [DEPTH_BASE2-1:0] c_PTR_ONE  = DEPTH_BASE2'(1);

    logic [DEPTH_BASE2-1:0] r_wr_ptr;
    logic [DEPTH_BASE2-1:0] r_rd_ptr;
    logic [DEPTH_BASE2:0]   r_count;
    logic                   r_data_out_v;
    logic                   w_wr_acc;
    logic                   w_rd_acc;

    // Acceptance uses only registered flags, so a write into an empty FIFO
    // and a read from a full one never touch the same address in one cycle.
    assign w_wr_acc = wr_en && !full;
    assign w_rd_acc = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out_v <= 1'b0;
        end else begin
            r_data_out_v <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    ase_svfifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_BASE2)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_out)
    );

    assign data_out_v = r_data_out_v;
    assign count      = r_count;
    assign empty      = (r_count == '0);
    assign full       = (r_count == c_CNT_FULL);
    assign alm_full   = (r_count >= c_CNT_ALM);

`ifdef ASE_SVFIFO_ERRCHK_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en && full;
            r_underflow <= rd_en && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en && full) begin
            $error("%m: write dropped, FIFO full");
        end
        if (!rst && rd_en && empty) begin
            $error("%m: read dropped, FIFO empty");
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule : ase_svfifo
`default_nettype wire

// File: tb/tb_ase_svfifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ase_svfifo                                                   |
// | Brief    : Randomized self-checking bench for ase_svfifo, queue model.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ase_svfifo;

    localparam int c_DW    = 64;
    localparam int c_AB    = 4;
    localparam int c_TH    = 5;
    localparam int c_DEPTH = 16;
`ifdef ASE_SVFIFO_ERRCHK_EN
    localparam bit c_ERRCHK = 1'b1;
`else
    localparam bit c_ERRCHK = 1'b0;
`endif

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              wr_en   = 1'b0;
    logic              rd_en   = 1'b0;
    logic [c_DW-1:0]   data_in = '0;
    logic [c_DW-1:0]   data_out;
    logic              data_out_v;
    logic              alm_full;
    logic              full;
    logic              empty;
    logic [c_AB:0]     count;
    logic              overflow;
    logic              underflow;

    ase_svfifo #(
        .DATA_WIDTH     (c_DW),
        .DEPTH_BASE2    (c_AB),
        .ALMFULL_THRESH (c_TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_out_v (data_out_v),
        .alm_full   (alm_full),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: contents as a plain queue plus last read word.
    logic [c_DW-1:0] m_q[$];
    logic [c_DW-1:0] m_do  = '0;
    bit              m_dv  = 1'b0;
    bit              m_ovf = 1'b0;
    bit              m_unf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_do  = '0;
        m_dv  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},     64'(count),      64'(m_q.size()));
        chk({tag, ".empty"},     64'(empty),      64'(m_q.size() == 0));
        chk({tag, ".full"},      64'(full),       64'(m_q.size() == c_DEPTH));
        chk({tag, ".alm_full"},  64'(alm_full),   64'(m_q.size() >= c_DEPTH - c_TH));
        chk({tag, ".dv"},        64'(data_out_v), 64'(m_dv));
        chk({tag, ".data_out"},  data_out,        m_do);
        chk({tag, ".overflow"},  64'(overflow),   64'(m_ovf));
        chk({tag, ".underflow"}, 64'(underflow),  64'(m_unf));
    endtask

    // Advance one clock, apply the FIFO rules to the model, compare everything.
    task automatic step(input string tag);
        bit was_full;
        bit was_empty;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            was_full  = (m_q.size() == c_DEPTH);
            was_empty = (m_q.size() == 0);
            m_dv  = rd_en && !was_empty;
            m_ovf = c_ERRCHK && wr_en && was_full;
            m_unf = c_ERRCHK && rd_en && was_empty;
            if (m_dv) m_do = m_q.pop_front();
            if (wr_en && !was_full) m_q.push_back(data_in);
        end
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wbias[3];
        int rbias[3];
        logic [63:0] base;
        wbias = '{80, 20, 50};
        rbias = '{20, 80, 50};
        base  = 64'hCAFEBABE_00000000;

        // Reset state, both while held and after release.
        #12;
        model_reset();
        check_all("rst_hold");
        repeat (2) step("rst");
        @(negedge clk);
        rst = 1'b0;
        step("rel_idle");

        // Fill to full; almost-full must appear exactly at 11 entries.
        wr_en = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) begin
            data_in = base + 64'(i);
            step("fill");
            chk("fill.alm_edge", 64'(alm_full), 64'(i + 1 >= 11));
        end
        chk("fill.full16", 64'(full), 64'd1);

        // Write while full is dropped.
        data_in = 64'hDEAD_BEEF_DEAD_BEEF;
        step("ovf");
        chk("ovf.count16", 64'(count), 64'd16);
        wr_en = 1'b0;
        step("ovf_after");

        // Drain with rd_en held, then one extra read on empty.
        rd_en = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) begin
            step("drain");
            chk("drain.order", data_out, base + 64'(i));
        end
        chk("drain.empty", 64'(empty), 64'd1);
        step("unf");
        chk("unf.dv0", 64'(data_out_v), 64'd0);
        rd_en = 1'b0;
        step("unf_after");

        // Random traffic with write-heavy, read-heavy and balanced phases.
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 150; k++) begin
                wr_en   = ($urandom_range(0, 99) < wbias[p]);
                rd_en   = ($urandom_range(0, 99) < rbias[p]);
                data_in = {$urandom, $urandom};
                step("rand");
            end
        end

        // Drain, then fill to eight and overlap reads with writes.
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int k = 0; k < 20 && m_q.size() != 0; k++) step("predrain");
        chk("predrain.empty", 64'(empty), 64'd1);
        rd_en = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 64'h1111_0000_0000_0000 + 64'(i);
            step("to8");
        end
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 64'h2222_0000_0000_0000 + 64'(i);
            step("rw8");
            chk("rw8.count", 64'(count), 64'd8);
            chk("rw8.order", data_out, 64'h1111_0000_0000_0000 + 64'(i));
        end

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.empty", 64'(empty), 64'd1);
        check_all("arst");
        rd_en = 1'b0;
        step("arst_hold");

        // First operation after release is accepted on the next edge.
        rst     = 1'b0;
        wr_en   = 1'b1;
        data_in = 64'h0123_4567_89AB_CDEF;
        step("post_rst_wr");
        chk("post_rst.count1", 64'(count), 64'd1);
        wr_en = 1'b0;
        rd_en = 1'b1;
        step("post_rst_rd");
        chk("post_rst.data", data_out, 64'h0123_4567_89AB_CDEF);
        rd_en = 1'b0;
        step("idle_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_ase_svfifo
`default_nettype wire
